// File: rtl/audio_adc_receiver.sv
// WM8731 left-justified ADC receiver: oversampled pins -> {left,right} frames on valid/ready.
// Latency: out_valid ~SYNC_STAGES+2 clk after the right-LSB BCLK rise; a frame arriving while one is stalled is dropped (sticky overflow).
module audio_adc_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_done,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRC,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, lrc_sync_q, dat_sync_q;
    logic                   bclk_prev_q, bclk_rise_q, lrc_q, dat_q, lrc_prev_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_WIDTH-2:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  left_hold_q, left_hold_d;
    logic [DATA_WIDTH-1:0]  word;
    logic                   emit;
    logic [DATA_WIDTH-1:0]  left_q, right_q;
    logic                   valid_q, overflow_q;

    // Strobe and sampled LRC/DAT are registered together so all three pins stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lrc_sync_q  <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            bclk_rise_q <= 1'b0;
            lrc_q       <= 1'b0;
            dat_q       <= 1'b0;
            lrc_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
            lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], AUD_ADCLRC};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
            bclk_rise_q <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
            lrc_q       <= lrc_sync_q[SYNC_STAGES-1];
            dat_q       <= dat_sync_q[SYNC_STAGES-1];
            if (bclk_rise_q) lrc_prev_q <= lrc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        emit        = 1'b0;
        word        = {shift_q, dat_q};
        if (!cfg_done) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = SYNC;
        end else if (bclk_rise_q) begin
            case (state_q)
                SYNC: begin
                    if (lrc_q && !lrc_prev_q) begin
                        shift_d = word[DATA_WIDTH-2:0];
                        count_d = CNT_ONE;
                        state_d = LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    if (lrc_q == (state_q == LEFT)) begin
                        if (count_q < CNT_FULL) begin
                            shift_d = word[DATA_WIDTH-2:0];
                            count_d = count_q + CNT_ONE;
                            if (count_q == CNT_LAST) begin
                                if (state_q == LEFT) left_hold_d = word;
                                else                 emit        = 1'b1;
                            end
                        end
                    end else if (count_q == CNT_FULL) begin
                        shift_d = word[DATA_WIDTH-2:0];
                        count_d = CNT_ONE;
                        state_d = (state_q == LEFT) ? RIGHT : LEFT;
                    end else begin
                        // Channel switched before the word filled: lost alignment.
                        state_d = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            if (emit) begin
                if (!valid_q || out_ready) begin
                    left_q  <= left_hold_q;
                    right_q <= word;
                    valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign out_valid  = valid_q;
    assign overflow   = overflow_q;
endmodule

// File: doc/audio_adc_receiver.md
# audio_adc_receiver

Receives the stereo ADC stream from the WM8731 audio codec once the I2C initialisation sequence has configured it (master mode, MSB-first left-justified, 16-bit words, LRC high = left). Oversamples the codec's BCLK/ADCLRC/ADCDAT pins in the system clock domain, deserialises each channel word and presents one {left, right} frame per LRC period on a valid/ready stream to downstream DSP. Sits directly downstream of the codec configuration block; `cfg_done` from that block gates capture.

## Interface
- `DATA_WIDTH`, 16: bits captured per channel word.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth on each codec pin, minimum 2.
- `clk`  in  1  system clock; must be at least 4x AUD_BCLK.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_done`  in  1  codec configuration complete; capture runs only while high.
- `AUD_BCLK`  in  1  codec bit clock (asynchronous to clk).
- `AUD_ADCLRC`  in  1  codec ADC left/right clock (asynchronous).
- `AUD_ADCDAT`  in  1  codec ADC serial data (asynchronous).
- `left_data`  out  DATA_WIDTH  left sample of presented frame.
- `right_data`  out  DATA_WIDTH  right sample of presented frame.
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  downstream accepts frame.
- `overflow`  out  1  sticky: a completed frame was dropped.

## Operation
- All three pins pass through identical SYNC_STAGES chains, keeping their relative alignment. Rising-edge strobe `bclk_rise` = synced BCLK high and previous synced BCLK low.
- All capture actions occur only on `bclk_rise` cycles, sampling synced LRC and DAT.
- State machine:
  - IDLE: wait for `cfg_done`=1 -> SYNC.
  - SYNC: wait for a `bclk_rise` where LRC is 1 and LRC on the previous `bclk_rise` was 0 (start of left word); on that edge shift in bit, count=1 -> LEFT.
  - LEFT: each `bclk_rise` with LRC=1 shifts DAT into the MSB-first shift register while count < DATA_WIDTH; the bit at count = DATA_WIDTH-1 completes the word into the left holding register. Extra bits are ignored. First `bclk_rise` with LRC=0: if left word is complete, shift in the bit, count=1 -> RIGHT; otherwise discard and go to SYNC.
  - RIGHT: same, LRC=0. Completion of the right word (bit DATA_WIDTH-1) emits the frame. First `bclk_rise` with LRC=1: if the right word is complete, start a new left word (count=1) -> LEFT; otherwise discard and go to SYNC.
- Emission: if `out_valid`=0 or (`out_valid` & `out_ready`) in the emitting cycle, load `left_data`/`right_data` and hold `out_valid`=1. Otherwise drop the new frame, keep the old one and set `overflow`.
- Handshake: a transfer occurs on any cycle with `out_valid` & `out_ready`. Without a new emission, `out_valid` clears on the next cycle. `left_data`/`right_data` stay stable while `out_valid`=1.
- `cfg_done` falling in any state -> IDLE, partial words discarded. A pending `out_valid` frame is retained until accepted.

## Timing
- Reset (synchronous, takes effect on the clk edge where `reset`=1): state IDLE, synchroniser chains and shift register 0, `left_data`=0, `right_data`=0, `out_valid`=0, `overflow`=0. Reset mid-frame abandons the frame; after reset the block waits for the next full left word.
- Pin-to-strobe latency: a BCLK rising edge is seen as `bclk_rise` SYNC_STAGES+1 clk cycles after it meets setup at the first flop. A jitter of ±1 cycle is acceptable.
- `out_valid` rises on the clk edge after the `bclk_rise` cycle that captures the right-channel LSB.
- Throughput: one frame per LRC period. With `out_ready` held high, there are no drops at any legal BCLK rate.
- `overflow` is cleared only by `reset`.

## Test plan
- Basic frame: BCLK = clk/8, 32 BCLK per LRC period, left 0xA5C3, right 0x3C5A, `out_ready`=1 -> one frame with `left_data`=0xA5C3 and `right_data`=0x3C5A. `out_valid` is high exactly 1 cycle, SYNC_STAGES+2 cycles after the right LSB BCLK rise.
- Alignment: assert `cfg_done` mid right word, then send frames (0x1111, 0x2222) and (0x8001, 0x7FFE) -> the partial frame is not emitted; exactly these two frames appear, in order.
- Backpressure: `out_ready`=0 across two frames (0x0001/0x0002, 0x0003/0x0004) -> data holds 0x0001/0x0002, `overflow`=1. Raise `out_ready` -> 0x0001/0x0002 transfers; the next frame is the third one sent.
- Short word: LRC toggles after 10 left bits -> no frame emitted, resynchronises, the next full frame 0xFFFF/0x0000 is emitted correctly.
- Reset mid-frame: pulse `reset` after 8 right bits with `out_valid`=1 -> the next cycle has all outputs 0 and `overflow`=0; only the next complete frame is emitted.
- `cfg_done` drop: deassert mid left word -> no emission; reassert -> normal capture from the next left-word start.
